cpu_control_unit: RTL and testbench

- Instruction sequencer for the Mini-CPU.
- Captures one 16-bit instruction per start pulse and walks the FETCH/DECODE/READ/CALC/SHOW/STORE state sequence, driving the memory bank's state, opcode and address inputs.
- Computes the ALU result and hands it to the memory bank for write-back and to the display path.
- Waits on the memory bank's read/stored handshake flags; a timeout guards against a stalled handshake.

---
 rtl/cpu_control_unit.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the Mini-CPU: latches one instruction per start pulse,
// steps FETCH/DECODE/READ/CALC/SHOW/STORE and computes the ALU result for write-back.
module cpu_control_unit #(
    parameter int unsigned SHOW_CYCLES  = 4,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power_on,
    input  logic        start,
    input  logic [15:0] instruction,
    input  logic        read,
    input  logic        stored,
    input  logic [15:0] v1_ram,
    input  logic [15:0] v2_ram,
    output logic [2:0]  state_cpu,
    output logic [2:0]  opcode,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  addr3,
    output logic [15:0] store_value,
    output logic [15:0] display_value,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StRead   = 3'd3,
        StCalc   = 3'd4,
        StShow   = 3'd5,
        StStore  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        OpLoad    = 3'd0,
        OpAdd     = 3'd1,
        OpAddi    = 3'd2,
        OpSub     = 3'd3,
        OpSubi    = 3'd4,
        OpMul     = 3'd5,
        OpClear   = 3'd6,
        OpDisplay = 3'd7
    } op_e;

    // Counters start at 0 on state entry, so the last cycle is N-1.
    localparam logic [15:0] ShowLast = 16'(SHOW_CYCLES - 1);
    localparam logic [15:0] WaitLast = 16'(WAIT_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] v1_q, v1_d;
    logic [15:0] v2_q, v2_d;
    logic [15:0] store_q, store_d;
    logic [15:0] display_q, display_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        timeout;
    op_e         op;
    logic [15:0] imm5;
    logic [15:0] imm9;
    logic [15:0] mul_lo;
    logic [15:0] alu_result;

    assign op   = op_e'(instr_q[15:13]);
    assign imm5 = {{11{instr_q[4]}}, instr_q[4:0]};
    assign imm9 = {{7{instr_q[8]}}, instr_q[8:0]};
    // Low half of a product is identical for signed and unsigned operands.
    assign mul_lo = v1_q * imm5;

    always_comb begin
        alu_result = '0;
        case (op)
            OpLoad:    alu_result = imm9;
            OpAdd:     alu_result = v1_q + v2_q;
            OpAddi:    alu_result = v1_q + imm5;
            OpSub:     alu_result = v1_q - v2_q;
            OpSubi:    alu_result = v1_q - imm5;
            OpMul:     alu_result = mul_lo;
            OpDisplay: alu_result = v1_q;
            default:   alu_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            instr_q   <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            store_q   <= '0;
            display_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            store_q   <= store_d;
            display_q <= display_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            StOff:   state_d = StFetch;
            StFetch: if (start) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad:  state_d = StCalc;
                    OpClear: state_d = StStore;
                    default: state_d = StRead;
                endcase
            end
            StRead: begin
                if (read) begin
                    state_d = StCalc;
                end else if (cnt_q == WaitLast) begin
                    state_d = StFetch;
                    timeout = 1'b1;
                end
            end
            StCalc: state_d = StShow;
            StShow: begin
                if (cnt_q == ShowLast) begin
                    state_d = (op == OpDisplay) ? StFetch : StStore;
                end
            end
            StStore: begin
                if (stored) begin
                    state_d = StFetch;
                end else if (cnt_q == WaitLast) begin
                    state_d = StFetch;
                    timeout = 1'b1;
                end
            end
            default: state_d = StOff;
        endcase

        // Power-off takes priority over every transition, including an accepted start.
        if (!power_on) begin
            state_d = StOff;
            timeout = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StRead || state_q == StShow || state_q == StStore) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = '0;
        end
    end

    // Output and datapath logic
    always_comb begin
        instr_d   = instr_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        store_d   = store_q;
        display_d = display_q;
        error_d   = error_q;
        done_d    = 1'b0;

        if (power_on) begin
            if (state_q == StFetch && start) begin
                instr_d = instruction;
                error_d = 1'b0;
            end
            if (state_q == StDecode && op == OpClear) begin
                store_d = '0;
            end
            if (state_q == StRead && read) begin
                v1_d = v1_ram;
                v2_d = v2_ram;
            end
            if (state_q == StCalc) begin
                store_d   = alu_result;
                display_d = alu_result;
            end
            if (timeout) begin
                error_d = 1'b1;
            end
            done_d = (state_d == StFetch) && !timeout &&
                     (state_q == StShow || state_q == StStore);
        end
    end

    assign state_cpu     = state_q;
    assign opcode        = instr_q[15:13];
    assign addr1         = instr_q[12:9];
    assign addr2         = instr_q[8:5];
    assign addr3         = instr_q[4:1];
    assign store_value   = store_q;
    assign display_value = display_q;
    assign busy          = (state_q != StOff) && (state_q != StFetch);
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: walks each instruction class, the handshake
// timeouts, power-off priority and start filtering against hand-computed values.
module tb_cpu_control_unit;

    localparam int ShowN = 4;
    localparam int WaitN = 16;

    localparam logic [2:0] StOff    = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StRead   = 3'd3;
    localparam logic [2:0] StCalc   = 3'd4;
    localparam logic [2:0] StShow   = 3'd5;
    localparam logic [2:0] StStore  = 3'd6;

    logic        clk;
    logic        reset;
    logic        power_on;
    logic        start;
    logic [15:0] instruction;
    logic        read;
    logic        stored;
    logic [15:0] v1_ram;
    logic [15:0] v2_ram;
    logic [2:0]  state_cpu;
    logic [2:0]  opcode;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [3:0]  addr3;
    logic [15:0] store_value;
    logic [15:0] display_value;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    // Observations recorded by exec_read_op
    logic [14:0] obs_fields;
    logic [2:0]  obs_rd_state;
    logic [2:0]  obs_calc_state;
    logic [15:0] obs_sval;
    logic [15:0] obs_dval;
    int          obs_show_n;
    logic [2:0]  obs_post;
    logic        obs_done;
    logic [2:0]  obs_final;
    logic        obs_done_after;

    cpu_control_unit #(
        .SHOW_CYCLES (ShowN),
        .WAIT_TIMEOUT(WaitN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .power_on     (power_on),
        .start        (start),
        .instruction  (instruction),
        .read         (read),
        .stored       (stored),
        .v1_ram       (v1_ram),
        .v2_ram       (v2_ram),
        .state_cpu    (state_cpu),
        .opcode       (opcode),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3        (addr3),
        .store_value  (store_value),
        .display_value(display_value),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ins);
        start = 1'b1;
        instruction = ins;
        step(1);
        start = 1'b0;
        instruction = 16'h0000;
    endtask

    // Runs one instruction through READ (memory answers on the 2nd READ cycle), SHOW and STORE.
    task automatic exec_read_op(input logic [15:0] ins, input logic [15:0] v1,
                                input logic [15:0] v2);
        issue(ins);
        obs_fields = {opcode, addr1, addr2, addr3};
        step(1);
        obs_rd_state = state_cpu;
        step(1);
        read = 1'b1;
        v1_ram = v1;
        v2_ram = v2;
        step(1);
        read = 1'b0;
        v1_ram = 16'hDEAD;
        v2_ram = 16'hBEEF;
        obs_calc_state = state_cpu;
        step(1);
        obs_sval = store_value;
        obs_dval = display_value;
        obs_show_n = 0;
        for (int g = 0; g < 300 && state_cpu == StShow && display_value == obs_dval; g++) begin
            obs_show_n++;
            step(1);
        end
        obs_post = state_cpu;
        if (obs_post == StStore) begin
            stored = 1'b1;
            step(1);
            stored = 1'b0;
        end
        obs_done = done;
        obs_final = state_cpu;
        step(1);
        obs_done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        power_on = 1'b1;
        start = 1'b0;
        instruction = 16'h0000;
        read = 1'b0;
        stored = 1'b0;
        v1_ram = 16'h0000;
        v2_ram = 16'h0000;
        step(3);
        total++;
        if (state_cpu !== StOff) begin
            bad++; $display("FAIL reset_state: got %h want %h", state_cpu, StOff);
        end
        total++;
        if ({opcode, addr1, addr2, addr3, store_value, display_value, busy, done, error}
            !== 50'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {opcode, addr1, addr2, addr3, store_value, display_value, busy, done, error});
        end
        power_on = 1'b0;
        reset = 1'b0;
        step(2);
        total++;
        if (state_cpu !== StOff) begin
            bad++; $display("FAIL off_holds: got %h want %h", state_cpu, StOff);
        end
        power_on = 1'b1;
        total++;
        if (state_cpu !== StOff) begin
            bad++; $display("FAIL off_first_cycle: got %h want %h", state_cpu, StOff);
        end
        step(1);
        total++;
        if (state_cpu !== StFetch || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL power_up_fetch: got st=%h busy=%b done=%b want 1/0/0",
                            state_cpu, busy, done);
        end
    endtask

    task automatic test_load;
        issue(16'h062A);
        total++;
        if ({state_cpu, opcode, addr1, busy} !== {StDecode, 3'd0, 4'd3, 1'b1}) begin
            bad++; $display("FAIL load_decode: got st=%h op=%h a1=%h busy=%b want 2/0/3/1",
                            state_cpu, opcode, addr1, busy);
        end
        step(1);
        total++;
        if (state_cpu !== StCalc) begin
            bad++; $display("FAIL load_skips_read: got %h want %h", state_cpu, StCalc);
        end
        step(1);
        total++;
        if (state_cpu !== StShow || store_value !== 16'h002A || display_value !== 16'h002A) begin
            bad++; $display("FAIL load_result: got st=%h sv=%h dv=%h want 5/002a/002a",
                            state_cpu, store_value, display_value);
        end
        step(ShowN);
        total++;
        if (state_cpu !== StStore || store_value !== 16'h002A) begin
            bad++; $display("FAIL load_store: got st=%h sv=%h want 6/002a", state_cpu, store_value);
        end
        stored = 1'b1;
        step(1);
        stored = 1'b0;
        total++;
        if (state_cpu !== StFetch || done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL load_done: got st=%h done=%b busy=%b want 1/1/0",
                            state_cpu, done, busy);
        end
        step(1);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL load_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_add;
        exec_read_op(16'h2661, 16'h002A, 16'h002A);
        total++;
        if (obs_fields !== {3'd1, 4'd3, 4'd3, 4'd0}) begin
            bad++; $display("FAIL add_fields: got %h want %h", obs_fields, {3'd1, 4'd3, 4'd3, 4'd0});
        end
        total++;
        if (obs_rd_state !== StRead || obs_calc_state !== StCalc) begin
            bad++; $display("FAIL add_flow: got rd=%h calc=%h want 3/4", obs_rd_state, obs_calc_state);
        end
        total++;
        if (obs_sval !== 16'h0054) begin
            bad++; $display("FAIL add_result: got %h want 0054", obs_sval);
        end
        total++;
        if (obs_post !== StStore || obs_final !== StFetch || obs_done !== 1'b1
            || obs_done_after !== 1'b0) begin
            bad++; $display("FAIL add_done: got post=%h fin=%h done=%b after=%b want 6/1/1/0",
                            obs_post, obs_final, obs_done, obs_done_after);
        end
    endtask

    task automatic test_subi_mul;
        exec_read_op(16'h821F, 16'hFFFF, 16'h5555);
        total++;
        if (obs_sval !== 16'h0000 || obs_fields[14:12] !== 3'd4) begin
            bad++; $display("FAIL subi_result: got sv=%h op=%h want 0000/4",
                            obs_sval, obs_fields[14:12]);
        end
        exec_read_op(16'hA21E, 16'h0003, 16'h7777);
        total++;
        if (obs_sval !== 16'hFFFA) begin
            bad++; $display("FAIL mul_result: got %h want fffa", obs_sval);
        end
        total++;
        if (obs_post !== StStore || obs_done !== 1'b1) begin
            bad++; $display("FAIL mul_done: got post=%h done=%b want 6/1", obs_post, obs_done);
        end
    endtask

    task automatic test_display;
        exec_read_op(16'hE400, 16'h1234, 16'h0000);
        total++;
        if (obs_dval !== 16'h1234 || obs_fields[14:12] !== 3'd7) begin
            bad++; $display("FAIL display_value: got dv=%h op=%h want 1234/7",
                            obs_dval, obs_fields[14:12]);
        end
        total++;
        if (obs_show_n !== ShowN) begin
            bad++; $display("FAIL display_dwell: got %0d want %0d", obs_show_n, ShowN);
        end
        total++;
        if (obs_post !== StFetch || obs_done !== 1'b1 || obs_done_after !== 1'b0) begin
            bad++; $display("FAIL display_no_store: got post=%h done=%b after=%b want 1/1/0",
                            obs_post, obs_done, obs_done_after);
        end
    endtask

    task automatic test_timeout;
        int n;
        issue(16'h062A);
        step(2 + ShowN);
        n = 0;
        while (state_cpu == StStore && n < 100) begin
            n++;
            step(1);
        end
        total++;
        if (n !== WaitN) begin
            bad++; $display("FAIL store_timeout_len: got %0d want %0d", n, WaitN);
        end
        total++;
        if (state_cpu !== StFetch || error !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL store_timeout: got st=%h err=%b done=%b want 1/1/0",
                            state_cpu, error, done);
        end
        issue(16'h2661);
        total++;
        if (error !== 1'b0 || state_cpu !== StDecode) begin
            bad++; $display("FAIL error_clear: got err=%b st=%h want 0/2", error, state_cpu);
        end
        step(1);
        n = 0;
        while (state_cpu == StRead && n < 100) begin
            n++;
            step(1);
        end
        total++;
        if (n !== WaitN || state_cpu !== StFetch || error !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL read_timeout: got n=%0d st=%h err=%b done=%b want %0d/1/1/0",
                            n, state_cpu, error, done, WaitN);
        end
    endtask

    task automatic test_clear;
        issue(16'hC000);
        total++;
        if (state_cpu !== StDecode || error !== 1'b0 || store_value !== 16'h002A) begin
            bad++; $display("FAIL clear_decode: got st=%h err=%b sv=%h want 2/0/002a",
                            state_cpu, error, store_value);
        end
        step(1);
        total++;
        if (state_cpu !== StStore || store_value !== 16'h0000) begin
            bad++; $display("FAIL clear_store: got st=%h sv=%h want 6/0000", state_cpu, store_value);
        end
        stored = 1'b1;
        step(1);
        stored = 1'b0;
        total++;
        if (state_cpu !== StFetch || done !== 1'b1) begin
            bad++; $display("FAIL clear_done: got st=%h done=%b want 1/1", state_cpu, done);
        end
    endtask

    task automatic test_power;
        issue(16'h2661);
        step(1);
        power_on = 1'b0;
        step(1);
        total++;
        if ({state_cpu, busy, done, opcode, addr1} !== {StOff, 1'b0, 1'b0, 3'd1, 4'd3}) begin
            bad++; $display("FAIL power_off_read: got st=%h busy=%b done=%b op=%h a1=%h want 0/0/0/1/3",
                            state_cpu, busy, done, opcode, addr1);
        end
        power_on = 1'b1;
        step(1);
        start = 1'b1;
        power_on = 1'b0;
        instruction = 16'hE400;
        step(1);
        start = 1'b0;
        power_on = 1'b1;
        total++;
        if (state_cpu !== StOff || opcode !== 3'd1) begin
            bad++; $display("FAIL power_beats_start: got st=%h op=%h want 0/1", state_cpu, opcode);
        end
        step(1);
        issue(16'h062A);
        step(1);
        start = 1'b1;
        instruction = 16'hE400;
        step(1);
        start = 1'b0;
        instruction = 16'h0000;
        total++;
        if (state_cpu !== StShow || opcode !== 3'd0) begin
            bad++; $display("FAIL calc_start_ignored: got st=%h op=%h want 5/0", state_cpu, opcode);
        end
        step(ShowN);
        stored = 1'b1;
        step(1);
        stored = 1'b0;
        step(1);
        total++;
        if (state_cpu !== StFetch || done !== 1'b0) begin
            bad++; $display("FAIL start_not_queued: got st=%h done=%b want 1/0", state_cpu, done);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_subi_mul();
        test_display();
        test_timeout();
        test_clear();
        test_power();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1);
    end

endmodule
